// File: rtl/mo_pkg.sv
// Shared constants, derived-parameter helpers and the per-stage payload for the Montgomery multiplier.
// Payload fields are sized for the largest supported build; narrower builds zero-extend into them.
package mo_pkg;

    localparam int MO_KYBER_Q_M     = 8;
    localparam int MO_KYBER_Q_K     = 13;
    localparam int MO_DILITHIUM_Q_M = 13;
    localparam int MO_DILITHIUM_Q_K = 1023;

    localparam int MO_MAX_WIDTH = 32;
    localparam int MO_MAX_RADIX = 8;
    localparam int MO_MAX_TAG_W = 16;
    // Signed accumulator: |data| < Q < 2^WIDTH, plus headroom for d*a and the sign.
    localparam int MO_DATA_W    = MO_MAX_WIDTH + MO_MAX_RADIX + 2;

    function automatic longint mo_q(input int q_k, input int q_m);
        return longint'(q_k) * (longint'(1) << q_m) + 64'sd1;
    endfunction

    function automatic int mo_stages(input int width, input int radix_bits);
        return width / radix_bits;
    endfunction

    typedef struct packed {
        logic signed [MO_DATA_W-1:0]    data;
        logic        [MO_MAX_WIDTH-1:0] a;
        logic        [MO_MAX_WIDTH-1:0] b;
        logic        [MO_MAX_TAG_W-1:0] tag;
        logic                           valid;
    } mo_stage_t;

endpackage

// File: rtl/mo_mul_stage.sv
// One radix-2^R reduction step: add digit*a, cancel the low R bits with m*Q, arithmetic shift by R.
// Latency 1 cycle; i_en low holds the whole register (global stall).
// Backpressure: none locally, the enclosing pipeline drives i_en from its stall condition.
module mo_mul_stage
    import mo_pkg::*;
#(
    parameter int RADIX_BITS = 1,
    parameter int Q_M        = MO_KYBER_Q_M,
    parameter int Q_K        = MO_KYBER_Q_K,
    parameter int IDX        = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_en,
    input  mo_stage_t i_p,
    output mo_stage_t o_p
);

    localparam logic signed [MO_DATA_W-1:0] C_Q_HI = MO_DATA_W'(longint'(Q_K) << Q_M);

    logic        [RADIX_BITS-1:0] w_d;
    logic        [RADIX_BITS-1:0] w_m;
    logic signed [MO_DATA_W-1:0]  w_d_x;
    logic signed [MO_DATA_W-1:0]  w_a_x;
    logic signed [MO_DATA_W-1:0]  w_t;
    logic signed [MO_DATA_W-1:0]  w_m_x;
    logic signed [MO_DATA_W-1:0]  w_t_red;
    mo_stage_t                    r_p;

    assign w_d   = i_p.b[IDX*RADIX_BITS +: RADIX_BITS];
    assign w_d_x = MO_DATA_W'(w_d);
    assign w_a_x = MO_DATA_W'(i_p.a);
    assign w_t   = i_p.data + w_d_x * w_a_x;
    assign w_m   = w_t[RADIX_BITS-1:0];
    assign w_m_x = MO_DATA_W'(w_m);
    // Q = (Q_K << Q_M) + 1 and Q is 1 mod 2^R, so subtracting m*Q clears the low R bits.
    assign w_t_red = w_t - w_m_x * C_Q_HI - w_m_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p.data  <= w_t_red >>> RADIX_BITS;
            r_p.a     <= i_p.a;
            r_p.b     <= i_p.b;
            r_p.tag   <= i_p.tag;
            r_p.valid <= i_p.valid;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/mo_mul_pipe.sv
// Pipelined Montgomery multiplier (modified MWR2MM): result = a*b*2^-WIDTH mod Q, signed in (-Q,Q).
// Latency WIDTH/RADIX_BITS cycles; MO_MUL_FINAL_REDUCE_EN adds one stage normalising result to 0..Q-1.
// Backpressure: out_valid && !out_ready freezes every stage (global enable) and drops in_ready.
module mo_mul_pipe
    import mo_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int RADIX_BITS = 1,
    parameter int Q_M        = MO_KYBER_Q_M,
    parameter int Q_K        = MO_KYBER_Q_K,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STAGES = mo_stages(WIDTH, RADIX_BITS);

    mo_stage_t w_in;
    mo_stage_t w_pipe [0:STAGES-1];
    mo_stage_t w_last;
    logic      w_en;
    logic      w_unused;

    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    always_comb begin
        w_in       = '0;
        w_in.a     = MO_MAX_WIDTH'(a);
        w_in.b     = MO_MAX_WIDTH'(b);
        w_in.tag   = MO_MAX_TAG_W'(in_tag);
        w_in.valid = in_valid;
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        mo_stage_t w_src;
        if (gi == 0) begin : g_first
            assign w_src = w_in;
        end else begin : g_next
            assign w_src = w_pipe[gi-1];
        end
        mo_mul_stage #(
            .RADIX_BITS (RADIX_BITS),
            .Q_M        (Q_M),
            .Q_K        (Q_K),
            .IDX        (gi)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_en),
            .i_p  (w_src),
            .o_p  (w_pipe[gi])
        );
    end

    assign w_last = w_pipe[STAGES-1];

`ifdef MO_MUL_FINAL_REDUCE_EN
    localparam longint C_Q = mo_q(Q_K, Q_M);

    logic [WIDTH:0]   w_raw;
    logic [WIDTH:0]   r_res;
    logic [TAG_W-1:0] r_tag;
    logic             r_vld;

    assign w_raw = w_last.data[WIDTH:0];

    // Raw value lies in (-Q,Q), so a single conditional +Q lands in 0..Q-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_res <= '0;
            r_tag <= '0;
        end else if (w_en) begin
            r_vld <= w_last.valid;
            r_tag <= w_last.tag[TAG_W-1:0];
            r_res <= w_raw[WIDTH] ? w_raw + (WIDTH+1)'(C_Q) : w_raw;
        end
    end

    assign out_valid = r_vld;
    assign result    = r_res;
    assign out_tag   = r_tag;
`else
    assign out_valid = w_last.valid;
    assign result    = w_last.data[WIDTH:0];
    assign out_tag   = w_last.tag[TAG_W-1:0];
`endif

    assign w_unused = ^{w_last.a, w_last.b, w_last.data, w_last.tag};

endmodule

// File: doc/mo_mul_pipe.md
Name: mo_mul_pipe

Overview:
- Fully pipelined modular Montgomery multiplier for NTT butterflies, using the modified MWR2MM scheme.
- Generalised over operand width, radix (bits of b consumed per stage) and modulus of form Q = Q_K*2^Q_M + 1.
- Adds a valid/ready handshake with global stall, a pass-through tag and synchronous reset.
- Accepts one product per cycle; returns result ≡ a*b*2^(-WIDTH) mod Q.

Parameters:
- WIDTH, 12, operand width; Q < 2^WIDTH; must be a multiple of RADIX_BITS.
- RADIX_BITS, 1, bits of b consumed per stage; 1 <= RADIX_BITS <= Q_M.
- Q_M, 8, modulus shift; Q = Q_K*2^Q_M + 1.
- Q_K, 13, modulus multiplier (Kyber default gives Q = 3329).
- TAG_W, 8, sideband tag width carried alongside each operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept (= !stall)
- a  in  WIDTH  multiplicand, unsigned 0..Q-1
- b  in  WIDTH  multiplier, unsigned 0..Q-1
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- result  out  WIDTH+1  signed result
- out_tag  out  TAG_W  tag of the same operation

Behaviour:
- Reset, synchronous on posedge clk with rst=1:
  - All stage valid bits clear, so out_valid=0.
  - result=0 and out_tag=0.
  - Data and tag registers zeroed.
  - in_ready=1 during and after reset.
  - Reset mid-operation discards every in-flight operation; no partial result is emitted.
- STAGES = WIDTH/RADIX_BITS. Latency = STAGES cycles from the accepting edge to out_valid (plus 1 with the optional feature).
- Transfers:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall:
  - stall = out_valid && !out_ready.
  - While stall=1 every stage register, valid bit and tag holds; result and out_tag are stable.
  - When out_ready=1 the pipeline advances every cycle. Bubbles are not collapsed; the pipeline is a global-enable shift.
- Stage i (0..STAGES-1), with internal signed width WIDTH+RADIX_BITS+2 bits:
  - d = digit i of b (bits [i*R +: R], R = RADIX_BITS).
  - t = data_i + d*a_i.
  - m = t[R-1:0].
  - t' = t - m*Q, implemented as t - m*(Q_K<<Q_M) - m.
  - data_{i+1} = t' >>> R (arithmetic). The low R bits of t' are zero by construction, since Q ≡ 1 mod 2^R.
  - data_0 = 0. a, b and tag travel with their stage.
- Output range: signed, -Q < result < Q, with result ≡ a*b*2^(-WIDTH) mod Q.
- Boundaries:
  - a=0 or b=0 gives result 0.
  - a=b=Q-1 must not overflow the internal width.
  - Simultaneous accept and output in the same cycle are both legal; throughput is 1 per cycle.
  - Inputs outside 0..Q-1 give an undefined result but must not corrupt other in-flight operations.

Optional Feature:
- Macro: MO_MUL_FINAL_REDUCE_EN.
- When defined:
  - One extra registered stage adds Q when the value is negative.
  - result lies in 0..Q-1 with its MSB always 0.
  - Latency = STAGES+1.
  - The stage participates in stall and reset like the others.
- When undefined: result is signed -Q..Q with latency STAGES.

Decomposition:
- Shared package mo_pkg holds:
  - Kyber/Dilithium Q_M and Q_K constants.
  - The derived Q localparam function.
  - The STAGES function.
  - A stage payload struct typedef: data, a, b, tag, valid.
- Natural sub-module: mo_mul_stage, one combinational-plus-register radix-2^R reduction step with an enable input. The top instantiates STAGES copies via generate and adds the handshake and the optional final stage.

Test Plan:
- Default params (Q=3329, WIDTH=12, R=1); a=1, b=1 -> result ≡ 2704 (raw -625 or 2704; exactly 2704 with MO_MUL_FINAL_REDUCE_EN) after 12 cycles, tag preserved.
- a=767, b=1 -> ≡ 1; a=3328, b=3328 -> ≡ 2704; a=0, b=1234 -> 0.
- Random back-to-back stream of 1000 operations at RADIX_BITS=1, 2 and 4, checked against the reference model a*b*2704 mod 3329 -> no gaps in out_valid, tags in order.
- out_ready held low for 5 cycles mid-stream -> result and out_tag stable, in_ready=0, no loss or duplication afterwards.
- rst asserted for 1 cycle with 6 operations in flight -> out_valid=0 on the next cycle, none of the 6 ever emerge, a new operation issued right after completes correctly.
- Dilithium params (Q_M=13, Q_K=1023, WIDTH=24, R=2); a=1, b=1 -> result ≡ 2^(-24) mod 8380417, matching the model.
